// File: rtl/uart_rx_ctrl.sv
// Polls an AXI-lite UART Lite for RX data and packs two received bytes into a 16-bit word.
// Optional inter-byte timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
    parameter logic [3:0] STAT_ADDR      = 4'h8,
    parameter logic [3:0] RX_ADDR        = 4'h0,
    parameter bit         MSB_FIRST      = 1'b1,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [15:0] data,
    output logic        valid,
    input  logic        ready,
    output logic        drop
);

    typedef enum logic [2:0] {
        S_STAT_AR,
        S_STAT_R,
        S_DATA_AR,
        S_DATA_R,
        S_OUT
    } state_t;

    state_t      state_q;
    logic [3:0]  araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        valid_q;
    logic        drop_q;
    logic        byte_cnt_q;
    logic [7:0]  byte0_q;
    logic [15:0] data_q;

    logic        r_hs;
    logic        r_ok;
    logic        byte_store;
    logic [15:0] word_d;

    assign r_hs       = rvalid && rready_q;
    assign r_ok       = (rresp == 2'b00);
    assign byte_store = (state_q == S_DATA_R) && r_hs && r_ok;

    always_comb begin
        word_d = MSB_FIRST ? {byte0_q, rdata[7:0]} : {rdata[7:0], byte0_q};
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             unused_rdata;
    assign unused_rdata = ^rdata[31:8];
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata[31:8], TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_STAT_AR;
            araddr_q   <= STAT_ADDR;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            byte_cnt_q <= 1'b0;
            byte0_q    <= 8'h00;
            data_q     <= 16'h0000;
`ifdef UART_RX_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_STAT_AR: begin
                    araddr_q <= STAT_ADDR;
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                    end else if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_STAT_R;
                    end
                end
                S_STAT_R: begin
                    if (r_hs) begin
                        rready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        if (r_ok && rdata[0]) begin
                            araddr_q <= RX_ADDR;
                            state_q  <= S_DATA_AR;
                        end else begin
                            araddr_q <= STAT_ADDR;
                            state_q  <= S_STAT_AR;
                        end
                    end
                end
                S_DATA_AR: begin
                    araddr_q <= RX_ADDR;
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                    end else if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA_R;
                    end
                end
                S_DATA_R: begin
                    if (r_hs) begin
                        rready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        araddr_q  <= STAT_ADDR;
                        state_q   <= S_STAT_AR;
                        // An errored read leaves the partial word untouched.
                        if (r_ok) begin
                            if (!byte_cnt_q) begin
                                byte0_q    <= rdata[7:0];
                                byte_cnt_q <= 1'b1;
                            end else begin
                                byte_cnt_q <= 1'b0;
                                data_q     <= word_d;
                                valid_q    <= 1'b1;
                                arvalid_q  <= 1'b0;
                                state_q    <= S_OUT;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (ready) begin
                        valid_q   <= 1'b0;
                        arvalid_q <= 1'b1;
                        araddr_q  <= STAT_ADDR;
                        state_q   <= S_STAT_AR;
                    end
                end
                default: begin
                    state_q   <= S_STAT_AR;
                    araddr_q  <= STAT_ADDR;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
`ifdef UART_RX_TIMEOUT_EN
            // A byte landing in the same cycle wins over an expiring timeout.
            if (byte_store || !byte_cnt_q || state_q == S_OUT) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt_q  <= '0;
                byte_cnt_q <= 1'b0;
                drop_q     <= 1'b1;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
`endif
        end
    end

    assign araddr  = araddr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an MSB-first and an LSB-first instance driven in lockstep.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        ready = 1'b0;

    logic [3:0]  araddr, araddr_l;
    logic        arvalid, arvalid_l;
    logic        rready, rready_l;
    logic [15:0] data, data_l;
    logic        valid, valid_l;
    logic        drop, drop_l;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int drop_cnt = 0;

    uart_rx_ctrl #(.MSB_FIRST(1'b1), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .data(data), .valid(valid), .ready(ready), .drop(drop)
    );

    uart_rx_ctrl #(.MSB_FIRST(1'b0), .TIMEOUT_CYCLES(50)) dut_l (
        .clk(clk), .rst(rst),
        .araddr(araddr_l), .arvalid(arvalid_l), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_l),
        .data(data_l), .valid(valid_l), .ready(ready), .drop(drop_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (drop) drop_cnt <= drop_cnt + 1;
    end

    // One AXI-lite read as the slave: accept the address, then return d/resp.
    task automatic serve_read(input logic [7:0] d, input logic [1:0] resp, output logic [3:0] addr);
        int n;
        n = 0;
        while (!arvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!arvalid) begin
            n_err++;
            $display("FAIL arvalid_wait: arvalid=%0b after %0d cycles, required 1", arvalid, n);
        end
        addr = araddr;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = {24'h0, d};
        rresp  = resp;
        n = 0;
        while (!rready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!rready) begin
            n_err++;
            $display("FAIL rready_wait: rready=%0b after %0d cycles, required 1", rready, n);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        $display("read addr=%h rdata=%h rresp=%b", addr, d, resp);
    endtask

    task automatic accept_word;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        $display("word accepted");
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 6;
        if (arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
        if (rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", rready); end
        if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
        if (data !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h want 0000", data); end
        if (araddr !== 4'h8) begin n_err++; $display("FAIL rst_araddr: got %h want 8", araddr); end
        if (drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", drop); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp += 2;
        if (arvalid !== 1'b1) begin n_err++; $display("FAIL first_arvalid: got %b want 1", arvalid); end
        if (araddr !== 4'h8) begin n_err++; $display("FAIL first_araddr: got %h want 8", araddr); end
        $display("reset done");
    endtask

    task automatic test_basic;
        logic [3:0] a;
        int rx_reads;
        rx_reads = 0;
        for (int i = 0; i < 3; i++) begin
            serve_read(8'h00, 2'b00, a);
            n_cmp++;
            if (a !== 4'h8) begin n_err++; $display("FAIL poll_addr%0d: got %h want 8", i, a); end
        end
        serve_read(8'h01, 2'b00, a);
        serve_read(8'hA5, 2'b00, a);
        if (a == 4'h0) rx_reads++;
        serve_read(8'h01, 2'b00, a);
        n_cmp++;
        if (a !== 4'h8) begin n_err++; $display("FAIL second_poll_addr: got %h want 8", a); end
        serve_read(8'h3C, 2'b00, a);
        if (a == 4'h0) rx_reads++;
        n_cmp += 4;
        if (rx_reads != 2) begin n_err++; $display("FAIL rx_reads: got %0d want 2", rx_reads); end
        if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", valid); end
        if (data !== 16'hA53C) begin n_err++; $display("FAIL basic_data_msb: got %h want A53C", data); end
        if (data_l !== 16'h3CA5) begin n_err++; $display("FAIL basic_data_lsb: got %h want 3CA5", data_l); end
    endtask

    task automatic test_backpressure;
        int bad;
        int n;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (valid !== 1'b1 || data !== 16'hA53C || arvalid !== 1'b0 || rready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h arvalid=%b rready=%b want 1 A53C 0 0",
                         i, valid, data, arvalid, rready);
            end
        end
        accept_word();
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL after_accept_valid: got %b want 0", valid); end
        n = 0;
        while (!arvalid && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp += 2;
        if (arvalid !== 1'b1) begin n_err++; $display("FAIL resume_arvalid: got %b want 1", arvalid); end
        if (araddr !== 4'h8) begin n_err++; $display("FAIL resume_araddr: got %h want 8", araddr); end
    endtask

    task automatic test_error_resp;
        logic [3:0] a;
        serve_read(8'h01, 2'b00, a);
        serve_read(8'hFF, 2'b10, a);
        n_cmp += 2;
        if (a !== 4'h0) begin n_err++; $display("FAIL err_read_addr: got %h want 0", a); end
        if (valid !== 1'b0) begin n_err++; $display("FAIL err_valid: got %b want 0", valid); end
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h12, 2'b00, a);
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h34, 2'b00, a);
        n_cmp += 3;
        if (valid !== 1'b1) begin n_err++; $display("FAIL err_word_valid: got %b want 1", valid); end
        if (data !== 16'h1234) begin n_err++; $display("FAIL err_word_msb: got %h want 1234", data); end
        if (data_l !== 16'h3412) begin n_err++; $display("FAIL err_word_lsb: got %h want 3412", data_l); end
        accept_word();
    endtask

    task automatic test_reset_mid;
        logic [3:0] a;
        int n;
        int drop_base;
        drop_base = drop_cnt;
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h77, 2'b00, a);
        serve_read(8'h01, 2'b00, a);
        n = 0;
        while (!arvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (araddr !== 4'h0 || arvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_data_ar: araddr=%h arvalid=%b want 0 1", araddr, arvalid);
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        n_cmp++;
        if (rready !== 1'b1) begin n_err++; $display("FAIL mid_in_data_r: rready=%b want 1", rready); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (arvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_arvalid: got %b want 0", arvalid); end
        if (rready !== 1'b0) begin n_err++; $display("FAIL mid_rst_rready: got %b want 0", rready); end
        if (valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
        if (data !== 16'h0000) begin n_err++; $display("FAIL mid_rst_data: got %h want 0000", data); end
        if (araddr !== 4'h8) begin n_err++; $display("FAIL mid_rst_araddr: got %h want 8", araddr); end
        if (drop !== 1'b0) begin n_err++; $display("FAIL mid_rst_drop: got %b want 0", drop); end
        rst = 1'b0;
        $display("mid-transaction reset applied");
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h02, 2'b00, a);
        n_cmp += 4;
        if (valid !== 1'b1) begin n_err++; $display("FAIL mid_word_valid: got %b want 1", valid); end
        if (data !== 16'h0102) begin n_err++; $display("FAIL mid_word_msb: got %h want 0102", data); end
        if (data_l !== 16'h0201) begin n_err++; $display("FAIL mid_word_lsb: got %h want 0201", data_l); end
        if (drop_cnt != drop_base) begin n_err++; $display("FAIL mid_drop_count: got %0d want %0d", drop_cnt, drop_base); end
        accept_word();
    endtask

    task automatic test_timeout;
        logic [3:0] a;
        int t0;
        int drop_base;
        drop_base = drop_cnt;
        serve_read(8'h01, 2'b00, a);
        serve_read(8'h55, 2'b00, a);
        t0 = cyc;
        while (cyc - t0 < 60) serve_read(8'h00, 2'b00, a);
        serve_read(8'h01, 2'b00, a);
        serve_read(8'hBE, 2'b00, a);
`ifdef UART_RX_TIMEOUT_EN
        serve_read(8'h01, 2'b00, a);
        serve_read(8'hEF, 2'b00, a);
        n_cmp += 4;
        if (drop_cnt - drop_base != 1) begin n_err++; $display("FAIL tmo_drop_count: got %0d want 1", drop_cnt - drop_base); end
        if (valid !== 1'b1) begin n_err++; $display("FAIL tmo_valid: got %b want 1", valid); end
        if (data !== 16'hBEEF) begin n_err++; $display("FAIL tmo_word_msb: got %h want BEEF", data); end
        if (data_l !== 16'hEFBE) begin n_err++; $display("FAIL tmo_word_lsb: got %h want EFBE", data_l); end
`else
        n_cmp += 4;
        if (drop_cnt != drop_base) begin n_err++; $display("FAIL notmo_drop_count: got %0d want 0", drop_cnt - drop_base); end
        if (valid !== 1'b1) begin n_err++; $display("FAIL notmo_valid: got %b want 1", valid); end
        if (data !== 16'h55BE) begin n_err++; $display("FAIL notmo_word_msb: got %h want 55BE", data); end
        if (data_l !== 16'hBE55) begin n_err++; $display("FAIL notmo_word_lsb: got %h want BE55", data_l); end
`endif
        accept_word();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_error_resp();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
